line_stream_feeder: RTL and testbench
=====================================

Name: line_stream_feeder

Overview:
- Synthesizable replacement for the bench-driven line source in front of the Controller/Datapath core.
- Holds a 64-entry buffer of 25-bit (5x5) input lines and presents them one at a time on `line`/`count`.
- Waits for the core's per-line completion, then captures the core's 25-bit `mem` result into a 64-entry result buffer.
- A host loads the inputs before a run and reads the results after it.

Parameters:
- LINE_W, 25, width of one line (5x5 bits)
- DEPTH, 64, number of lines per run
- ADDR_W, 6, log2(DEPTH); also the width of `count`

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ld_en  in  1  host write strobe into the input buffer
- ld_addr  in  ADDR_W  input buffer write address
- ld_data  in  LINE_W  input buffer write data
- start  in  1  one-cycle pulse that begins a run
- line  out  LINE_W  current line presented to the core
- count  out  ADDR_W  index of the current line
- line_valid  out  1  `line`/`count` are stable and the core may consume them
- core_done  in  1  one-cycle pulse from the core: current line finished
- core_mem  in  LINE_W  core result, valid in the core_done cycle
- rd_addr  in  ADDR_W  result buffer read address
- rd_data  out  LINE_W  result buffer read data, registered, 1-cycle latency
- busy  out  1  run in progress
- run_done  out  1  one-cycle pulse after the final result is stored

Behaviour:
- Reset values (rst=0, asynchronous):
  - line=0, count=0, line_valid=0, busy=0, run_done=0, rd_data=0.
  - FSM goes to IDLE.
  - Buffer contents are not reset.
- States: IDLE, FETCH, PRESENT, CAPTURE, FINISH.
- IDLE:
  - ld_en writes ld_data to inbuf[ld_addr] on the clock edge.
  - start=1 → FETCH, with idx=0 and busy=1.
  - ld_en while busy is ignored.
- FETCH:
  - line<=inbuf[idx], count<=idx.
  - Next state is PRESENT; line_valid rises on entry to PRESENT.
  - Latency from start to line_valid=1 is 2 cycles.
- PRESENT:
  - Holds line, count and line_valid=1 until core_done=1.
  - On core_done: outbuf[idx]<=core_mem in that same edge, line_valid<=0, → CAPTURE.
- CAPTURE:
  - If idx==DEPTH-1 → FINISH.
  - Otherwise idx<=idx+1 → FETCH.
  - No wrap: idx never exceeds DEPTH-1.
- FINISH:
  - run_done=1 for exactly one cycle, busy<=0, → IDLE.
  - count keeps its last value (63).
- Each line costs 3 cycles of overhead plus the core's latency; there is no timeout, and PRESENT waits indefinitely.
- Boundary rules:
  - start while busy is ignored.
  - core_done outside PRESENT is ignored and writes nothing.
  - core_done in the first cycle of PRESENT is accepted.
  - rd_addr may be read at any time; reading during a run returns old or partial results, with no stall.
  - Reset mid-run aborts the run and returns to IDLE; outbuf keeps any partial contents.
  - ld_en and start in the same IDLE cycle: the write completes and the run starts; the run's FETCH of that address sees the new data.

Decomposition:
- Shared package holds LINE_W, DEPTH and ADDR_W, plus the state enum for the five states.
- One sub-module, `line_ram` (1 write port, 1 registered read port, DEPTH x LINE_W), instantiated twice: as inbuf and as outbuf.
- FETCH therefore accounts for the RAM read latency: the address is issued in CAPTURE or on start, and data is taken in FETCH.

Test Plan:
- Load inbuf[i]=i*3 for i=0..63, pulse start, core model returns core_mem=~line after 5 cycles → each line appears with count=i; outbuf[i]=~(i*3); exactly one run_done; busy falls on the same edge.
- After reset, check outputs: line=0, count=0, line_valid=0, busy=0, run_done=0.
- core_done pulsed while IDLE and in FETCH → no outbuf write: the read-back of addresses 0..63 is unchanged from pre-filled 25'h1555555.
- Second start pulsed at line 10 → ignored; run proceeds to count=63 and a single run_done.
- rst driven low while count=20 and PRESENT → all outputs reset immediately, without waiting for clk. Then a new start: line 0 is re-presented and outbuf[0..19] from the first run is intact until overwritten.
- ld_en with ld_addr=0, data 25'h0ABCDEF plus start in the same cycle → the first line presented is 25'h0ABCDEF, count=0. rd_addr=0 after the run gives rd_data one cycle later equal to the core result for that line.

Source files
------------

// File: rtl/line_stream_feeder_pkg.sv
// Shared sizes, FSM state encoding and RAM write payload for the line stream feeder.
package line_stream_feeder_pkg;

  localparam int unsigned LINE_W = 25;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_CAPTURE,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } ram_wr_t;

endpackage

// File: rtl/line_stream_feeder_line_ram.sv
// DEPTH x LINE_W buffer: one write port, one registered read port (write-first on collision).
module line_ram
  import line_stream_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  ram_wr_t           wr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr.en) mem[wr.addr] <= wr.data;
  end

  // Bypass lets a load and a run start in the same cycle see the fresh word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           rdata <= '0;
    else if (wr.en && wr.addr == raddr) rdata <= wr.data;
    else                                rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_stream_feeder.sv
// Presents buffered input lines to the core one at a time and captures each core result.
module line_stream_feeder
  import line_stream_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [LINE_W-1:0] ld_data,
  input  logic              start,
  output logic [LINE_W-1:0] line,
  output logic [ADDR_W-1:0] count,
  output logic              line_valid,
  input  logic              core_done,
  input  logic [LINE_W-1:0] core_mem,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LINE_W-1:0] rd_data,
  output logic              busy,
  output logic              run_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt, count_nxt;
  logic [LINE_W-1:0] line_nxt;
  logic              line_valid_nxt, busy_nxt, run_done_nxt;

  ram_wr_t           in_wr, out_wr;
  logic [ADDR_W-1:0] in_raddr;
  logic [LINE_W-1:0] in_rdata;

  line_ram u_inbuf (
    .clk   (clk),
    .rst   (rst),
    .wr    (in_wr),
    .raddr (in_raddr),
    .rdata (in_rdata)
  );

  line_ram u_outbuf (
    .clk   (clk),
    .rst   (rst),
    .wr    (out_wr),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      line       <= '0;
      count      <= '0;
      line_valid <= 1'b0;
      busy       <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      line       <= line_nxt;
      count      <= count_nxt;
      line_valid <= line_valid_nxt;
      busy       <= busy_nxt;
      run_done   <= run_done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_PRESENT;
      S_PRESENT: if (core_done) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = (idx == LAST_IDX) ? S_FINISH : S_FETCH;
      S_FINISH:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Input-buffer read address is issued one cycle ahead so FETCH sees registered data.
  always_comb begin
    idx_nxt        = idx;
    line_nxt       = line;
    count_nxt      = count;
    line_valid_nxt = line_valid;
    busy_nxt       = busy;
    run_done_nxt   = 1'b0;
    in_wr          = '{en: ld_en && (state == S_IDLE), addr: ld_addr, data: ld_data};
    out_wr         = '{en: 1'b0, addr: idx, data: core_mem};
    in_raddr       = idx;
    case (state)
      S_IDLE: begin
        in_raddr = '0;
        if (start) begin
          idx_nxt  = '0;
          busy_nxt = 1'b1;
        end
      end
      S_FETCH: begin
        line_nxt       = in_rdata;
        count_nxt      = idx;
        line_valid_nxt = 1'b1;
      end
      S_PRESENT: begin
        if (core_done) begin
          out_wr.en      = 1'b1;
          line_valid_nxt = 1'b0;
        end
      end
      S_CAPTURE: begin
        in_raddr = ADDR_W'(idx + 1'b1);
        if (idx != LAST_IDX) idx_nxt = in_raddr;
      end
      S_FINISH: begin
        run_done_nxt = 1'b1;
        busy_nxt     = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_stream_feeder.sv
// Directed bench for line_stream_feeder with a cycle-level reference model and a scripted core.
module tb_line_stream_feeder;
  import line_stream_feeder_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [LINE_W-1:0] ld_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [LINE_W-1:0] line, rd_data, core_mem;
  logic [ADDR_W-1:0] count;
  logic              line_valid, busy, run_done, core_done;

  logic              model_done = 1'b0, host_done = 1'b0;
  logic [LINE_W-1:0] model_mem = '0, host_mem = '0;
  int                core_mode = 0;  // 0: silent, 1: returns ~line, 2: returns constant
  localparam logic [LINE_W-1:0] FILL = 25'h1555555;

  logic              rb_en = 1'b0, timeout = 1'b0;
  logic              pin_first_en = 1'b0, pin_rd_en = 1'b0;
  logic [LINE_W-1:0] pin_first_val = '0, pin_rd_val = '0;

  int n_checks = 0, n_fail = 0;

  assign core_done = model_done | host_done;
  assign core_mem  = host_done ? host_mem : model_mem;

  line_stream_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .line       (line),
    .count      (count),
    .line_valid (line_valid),
    .core_done  (core_done),
    .core_mem   (core_mem),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .run_done   (run_done)
  );

  always #5 clk = ~clk;

  // Core stand-in: answers 5 cycles after it sees a valid line.
  initial begin : core_model
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      model_done = 1'b0;
      if (core_mode != 0 && line_valid) begin
        wait_cnt++;
        if (wait_cnt == 5) begin
          model_done = 1'b1;
          model_mem  = (core_mode == 1) ? ~line : FILL;
          wait_cnt   = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Reference model state: what the feeder must show, derived from the run protocol.
  logic [LINE_W-1:0] m_in  [DEPTH];
  logic [LINE_W-1:0] m_out [DEPTH];
  logic              m_busy = 1'b0, m_lv = 1'b0, m_done = 1'b0, m_first = 1'b0;
  logic              nxt_lv, nxt_busy, nxt_done, prev_lv = 1'b0;
  int                m_idx = 0, m_wait = 0, m_fin = 0, lv_rises = 0;
  logic              rb_pend = 1'b0, rb_pin_pend = 1'b0;
  logic [LINE_W-1:0] rb_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_line", line, 32'd0);
      chk("rst_count", count, 32'd0);
      chk("rst_line_valid", line_valid, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_run_done", run_done, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      m_busy = 1'b0; m_lv = 1'b0; m_done = 1'b0; m_first = 1'b0; prev_lv = 1'b0;
      m_idx = 0; m_wait = 0; m_fin = 0;
      rb_pend = 1'b0; rb_pin_pend = 1'b0;
    end else begin
      if (timeout) chk("wait_bound", timeout, 32'd0);
      chk("busy", busy, m_busy);
      chk("run_done", run_done, m_done);
      chk("line_valid", line_valid, m_lv);
      if (m_lv) begin
        chk("line", line, m_in[m_idx]);
        chk("count", count, m_idx);
        if (m_first && pin_first_en) chk("first_line_pin", line, pin_first_val);
        m_first = 1'b0;
      end
      if (line_valid && !prev_lv) lv_rises++;
      prev_lv = line_valid;
      if (m_done) chk("lines_per_run", lv_rises, DEPTH);
      if (rb_pend) chk("rd_data", rd_data, rb_exp);
      if (rb_pin_pend) chk("rd_data_pin", rd_data, pin_rd_val);

      // advance the model across the coming clock edge
      nxt_lv = m_lv; nxt_busy = m_busy; nxt_done = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) nxt_lv = 1'b1;
      end
      if (m_fin > 0) begin
        m_fin--;
        if (m_fin == 0) begin nxt_done = 1'b1; nxt_busy = 1'b0; end
      end
      if (ld_en && !m_busy) m_in[ld_addr] = ld_data;
      if (start && !m_busy) begin
        nxt_busy = 1'b1; m_idx = 0; m_wait = 1; m_first = 1'b1; lv_rises = 0;
      end
      if (core_done && m_lv) begin
        m_out[m_idx] = (core_mode == 2) ? FILL : ~m_in[m_idx];
        nxt_lv = 1'b0;
        if (m_idx == DEPTH - 1) m_fin = 2;
        else begin m_idx++; m_wait = 2; end
      end
      rb_pend     = rb_en;
      if (rb_en) rb_exp = m_out[rd_addr];
      rb_pin_pend = rb_en && pin_rd_en && (rd_addr == '0);
      m_lv = nxt_lv; m_busy = nxt_busy; m_done = nxt_done;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic flag_timeout();
    timeout = 1'b1; tick(); timeout = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    for (n = 0; n < limit; n++) begin
      tick();
      if (run_done) break;
    end
    if (n == limit) flag_timeout();
  endtask

  task automatic wait_count(input int c, input int limit);
    int n;
    for (n = 0; n < limit; n++) begin
      if (line_valid && count == ADDR_W'(c)) break;
      tick();
    end
    if (n == limit) flag_timeout();
  endtask

  task automatic readback();
    for (int i = 0; i < DEPTH; i++) begin
      rb_en = 1'b1; rd_addr = ADDR_W'(i); tick();
    end
    rb_en = 1'b0;
    tick(); tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b0; #6; rst = 1'b1;
    tick();
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // full run over inbuf[i] = i*3 with an inverting core
    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1'b1; ld_addr = ADDR_W'(i); ld_data = LINE_W'(i * 3); tick();
    end
    ld_en = 1'b0;
    core_mode = 1; pin_first_en = 1'b1; pin_first_val = '0;
    pulse_start();
    wait_done(1000);
    readback();

    // fill outbuf with a constant pattern
    core_mode = 2; pin_first_en = 1'b0;
    pulse_start();
    wait_done(1000);
    readback();

    // core_done in IDLE and in FETCH must not write, then abort the stalled run
    core_mode = 0; host_mem = '0;
    host_done = 1'b1; tick(); host_done = 1'b0;
    pulse_start();
    host_done = 1'b1; tick(); host_done = 1'b0;
    repeat (4) tick();
    async_reset();
    readback();

    // abort a run in PRESENT at line 20; outbuf keeps the partial results
    core_mode = 1; pin_first_en = 1'b1; pin_first_val = '0;
    pulse_start();
    wait_count(20, 1000);
    async_reset();
    readback();

    // rerun: second start and a load while busy are both ignored
    pulse_start();
    wait_count(10, 1000);
    pulse_start();
    ld_en = 1'b1; ld_addr = ADDR_W'(5); ld_data = '1; tick(); ld_en = 1'b0;
    wait_done(1000);
    readback();

    // load and start in the same cycle
    pin_first_val = 25'h0ABCDEF;
    ld_en = 1'b1; ld_addr = '0; ld_data = 25'h0ABCDEF; start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    wait_done(1000);
    pin_rd_en = 1'b1; pin_rd_val = 25'h1543210;
    rb_en = 1'b1; rd_addr = '0; tick();
    rb_en = 1'b0; tick(); tick();
    pin_rd_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
